// File: rtl/exec_sched.sv
// exec_sched: issue scheduler in front of the Execution stage.
// It decides each cycle whether the decoded instruction enters EX.
// A two-state FSM and a down-counter hold EX while a multi-cycle MUL runs.
// It detects load-use hazards and stalls decode for one cycle on each one.
// It tracks the EX and MEM destinations to drive the forwarding selects.
module exec_sched #(
    parameter int unsigned MUL_LAT = 4,
    parameter logic [6:0]  OP_MUL  = 7'h02,
    parameter logic [6:0]  OP_LDW  = 7'h10,
    parameter logic [6:0]  OP_LDB  = 7'h11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [6:0]  id_opcode,
    input  logic [4:0]  id_dst,
    input  logic [4:0]  id_src1_reg,
    input  logic [4:0]  id_src2_reg,
    input  logic        flush,
    output logic        ex_enable,
    output logic        stall_id,
    output logic [4:0]  bp_reg,
    output logic [4:0]  bp_reg_mem,
    output logic        ex_nop,
    output logic        mul_busy,
    output logic [15:0] stall_cnt
);

    typedef enum logic [0:0] {StRun, StMulBusy} state_e;

    // The issue edge counts as the first MUL cycle, so the counter starts one short.
    localparam logic [3:0] MulCntInit = 4'(MUL_LAT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ex_vld_q, ex_vld_d;
    logic [4:0]  ex_dst_q, ex_dst_d;
    logic        ex_load_q, ex_load_d;
    logic        mem_vld_q, mem_vld_d;
    logic [4:0]  mem_dst_q, mem_dst_d;
    logic [15:0] stall_cnt_q;
    logic        luh;
    logic        id_is_load;
    logic        run;

    // Hazard detection and issue/stall decisions.
    always_comb begin
        run        = (state_q == StRun);
        id_is_load = (id_opcode == OP_LDW) || (id_opcode == OP_LDB);
        luh        = ex_vld_q && ex_load_q && (ex_dst_q != 5'd0) &&
                     ((ex_dst_q == id_src1_reg) || (ex_dst_q == id_src2_reg));
        ex_enable  = id_valid && !flush && run && !luh;
        stall_id   = !flush && id_valid && (!run || luh);
    end

    // Forwarding selects and status outputs, all from registered state.
    always_comb begin
        // Loads are not forwardable from EX; their data exists only at MEM.
        bp_reg     = (ex_vld_q && !ex_load_q && run && (ex_dst_q != 5'd0)) ? ex_dst_q : 5'd0;
        bp_reg_mem = (mem_vld_q && (mem_dst_q != 5'd0)) ? mem_dst_q : 5'd0;
        ex_nop     = !ex_vld_q;
        mul_busy   = (state_q == StMulBusy);
        stall_cnt  = stall_cnt_q;
    end

    // Next-state for the FSM, MUL counter and the EX/MEM trackers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ex_vld_d  = ex_vld_q;
        ex_dst_d  = ex_dst_q;
        ex_load_d = ex_load_q;
        mem_vld_d = mem_vld_q;
        mem_dst_d = mem_dst_q;

        if (flush) begin
            // A RUN-state EX occupant is older than the fault and still commits;
            // a MUL still in progress is killed.
            if (run) begin
                mem_vld_d = ex_vld_q;
                mem_dst_d = ex_dst_q;
            end else begin
                mem_vld_d = 1'b0;
            end
            ex_vld_d = 1'b0;
            state_d  = StRun;
            cnt_d    = 4'd0;
        end else begin
            unique case (state_q)
                StRun: begin
                    mem_vld_d = ex_vld_q;
                    mem_dst_d = ex_dst_q;
                    if (ex_enable) begin
                        ex_vld_d  = 1'b1;
                        ex_dst_d  = id_dst;
                        ex_load_d = id_is_load;
                        if (id_opcode == OP_MUL) begin
                            state_d = StMulBusy;
                            cnt_d   = MulCntInit;
                        end
                    end else begin
                        ex_vld_d = 1'b0;
                    end
                end
                StMulBusy: begin
                    mem_vld_d = 1'b0;
                    if (cnt_q == 4'd1) begin
                        state_d = StRun;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = StRun;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StRun;
            cnt_q     <= 4'd0;
            ex_vld_q  <= 1'b0;
            ex_dst_q  <= 5'd0;
            ex_load_q <= 1'b0;
            mem_vld_q <= 1'b0;
            mem_dst_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ex_vld_q  <= ex_vld_d;
            ex_dst_q  <= ex_dst_d;
            ex_load_q <= ex_load_d;
            mem_vld_q <= mem_vld_d;
            mem_dst_q <= mem_dst_d;
        end
    end

    // Saturating count of stalled decode cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else if (stall_id && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_exec_sched.sv
// tb_exec_sched: directed test-plan scenarios plus randomized traffic, each
// cycle compared against a behavioural pipeline model of the scheduler.
module tb_exec_sched;

    localparam int MUL_LAT = 4;
    localparam logic [6:0] OP_ADD = 7'h00;
    localparam logic [6:0] OP_SUB = 7'h01;
    localparam logic [6:0] OP_MUL = 7'h02;
    localparam logic [6:0] OP_LDW = 7'h10;
    localparam logic [6:0] OP_LDB = 7'h11;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_dst;
    logic [4:0]  id_src1_reg;
    logic [4:0]  id_src2_reg;
    logic        flush;
    logic        ex_enable;
    logic        stall_id;
    logic [4:0]  bp_reg;
    logic [4:0]  bp_reg_mem;
    logic        ex_nop;
    logic        mul_busy;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    exec_sched #(
        .MUL_LAT(MUL_LAT),
        .OP_MUL (OP_MUL),
        .OP_LDW (OP_LDW),
        .OP_LDB (OP_LDB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_opcode  (id_opcode),
        .id_dst     (id_dst),
        .id_src1_reg(id_src1_reg),
        .id_src2_reg(id_src2_reg),
        .flush      (flush),
        .ex_enable  (ex_enable),
        .stall_id   (stall_id),
        .bp_reg     (bp_reg),
        .bp_reg_mem (bp_reg_mem),
        .ex_nop     (ex_nop),
        .mul_busy   (mul_busy),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: what sits in EX and MEM, and how many busy cycles remain.
    logic       m_ex_vld, m_ex_load, m_mem_vld;
    logic [4:0] m_ex_dst, m_mem_dst;
    int         m_busy_left;
    int         m_stalls;

    logic       p_en, p_stall, p_nop, p_busy;
    logic [4:0] p_bp, p_bpm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ex_vld = 0; m_ex_load = 0; m_ex_dst = 0;
        m_mem_vld = 0; m_mem_dst = 0;
        m_busy_left = 0; m_stalls = 0;
    endtask

    task automatic predict();
        logic run, hazard;
        run    = (m_busy_left == 0);
        hazard = m_ex_vld && m_ex_load && (m_ex_dst != 0) &&
                 ((m_ex_dst == id_src1_reg) || (m_ex_dst == id_src2_reg));
        p_en    = id_valid && !flush && run && !hazard;
        p_stall = id_valid && !flush && (!run || hazard);
        p_bp    = (m_ex_vld && !m_ex_load && run) ? m_ex_dst : 5'd0;
        p_bpm   = m_mem_vld ? m_mem_dst : 5'd0;
        p_nop   = !m_ex_vld;
        p_busy  = !run;
    endtask

    task automatic model_edge();
        predict();
        if (p_stall && m_stalls < 65535) m_stalls++;
        if (flush) begin
            if (m_busy_left == 0) begin
                m_mem_vld = m_ex_vld; m_mem_dst = m_ex_dst;
            end else begin
                m_mem_vld = 0;
            end
            m_ex_vld = 0;
            m_busy_left = 0;
        end else if (m_busy_left == 0) begin
            m_mem_vld = m_ex_vld; m_mem_dst = m_ex_dst;
            if (p_en) begin
                m_ex_vld  = 1;
                m_ex_dst  = id_dst;
                m_ex_load = (id_opcode == OP_LDW) || (id_opcode == OP_LDB);
                m_busy_left = (id_opcode == OP_MUL) ? MUL_LAT - 1 : 0;
            end else begin
                m_ex_vld = 0;
            end
        end else begin
            m_mem_vld = 0;
            m_busy_left--;
        end
    endtask

    task automatic compare_model();
        predict();
        check("ex_enable", 32'(ex_enable), 32'(p_en));
        check("stall_id", 32'(stall_id), 32'(p_stall));
        check("bp_reg", 32'(bp_reg), 32'(p_bp));
        check("bp_reg_mem", 32'(bp_reg_mem), 32'(p_bpm));
        check("ex_nop", 32'(ex_nop), 32'(p_nop));
        check("mul_busy", 32'(mul_busy), 32'(p_busy));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
    endtask

    // Apply decode inputs just after an edge, then compare at the falling edge.
    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] dst,
                         input logic [4:0] s1, input logic [4:0] s2, input logic fl);
        id_valid = v; id_opcode = op; id_dst = dst;
        id_src1_reg = s1; id_src2_reg = s2; flush = fl;
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle();
        drive(1'b0, OP_ADD, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        id_valid = 0; flush = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic       hold;
        logic [6:0] r_op;
        logic [4:0] r_dst, r_s1, r_s2;
        logic       r_v;

        rst = 1'b1;
        id_valid = 0; id_opcode = 0; id_dst = 0; id_src1_reg = 0; id_src2_reg = 0; flush = 0;
        model_reset();
        #1;
        check("rst_ex_nop", 32'(ex_nop), 32'd1);
        check("rst_mul_busy", 32'(mul_busy), 32'd0);
        check("rst_bp_reg", 32'(bp_reg), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU chain: ADD r3, then SUB reading r3.
        drive(1, OP_ADD, 5'd3, 5'd1, 5'd2, 0);
        check("alu_issue0", 32'(ex_enable), 32'd1);
        tick();
        drive(1, OP_SUB, 5'd8, 5'd3, 5'd2, 0);
        check("alu_nostall", 32'(stall_id), 32'd0);
        check("alu_bp3", 32'(bp_reg), 32'd3);
        tick();
        idle();
        check("alu_bp8", 32'(bp_reg), 32'd8);
        check("alu_bpm3", 32'(bp_reg_mem), 32'd3);
        tick();
        idle();
        check("alu_bpm8", 32'(bp_reg_mem), 32'd8);
        tick();
        idle();
        check("alu_clear", 32'({bp_reg, bp_reg_mem}), 32'd0);

        // Load-use: LDW r5, then ADD reading r5 stalls one cycle.
        do_reset();
        drive(1, OP_LDW, 5'd5, 5'd1, 5'd2, 0);
        tick();
        drive(1, OP_ADD, 5'd9, 5'd1, 5'd5, 0);
        check("lu_stall", 32'(stall_id), 32'd1);
        check("lu_noissue", 32'(ex_enable), 32'd0);
        check("lu_no_ex_fwd", 32'(bp_reg), 32'd0);
        tick();
        drive(1, OP_ADD, 5'd9, 5'd1, 5'd5, 0);
        check("lu_issue", 32'(ex_enable), 32'd1);
        check("lu_bubble", 32'(ex_nop), 32'd1);
        check("lu_bpm5", 32'(bp_reg_mem), 32'd5);
        tick();
        idle();
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        check("lu_bp9", 32'(bp_reg), 32'd9);
        tick();

        // Register 0 never hazards.
        do_reset();
        drive(1, OP_LDW, 5'd0, 5'd1, 5'd2, 0);
        tick();
        drive(1, OP_ADD, 5'd4, 5'd0, 5'd2, 0);
        check("r0_nostall", 32'(stall_id), 32'd0);
        check("r0_issue", 32'(ex_enable), 32'd1);
        tick();

        // MUL r8 then a dependent ADD held valid.
        do_reset();
        drive(1, OP_MUL, 5'd8, 5'd1, 5'd2, 0);
        tick();
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            drive(1, OP_ADD, 5'd4, 5'd8, 5'd2, 0);
            check("mul_busy", 32'(mul_busy), 32'd1);
            check("mul_stall", 32'(stall_id), 32'd1);
            check("mul_hide_bp", 32'(bp_reg), 32'd0);
            tick();
        end
        drive(1, OP_ADD, 5'd4, 5'd8, 5'd2, 0);
        check("mul_run", 32'(mul_busy), 32'd0);
        check("mul_bp8", 32'(bp_reg), 32'd8);
        check("mul_issue", 32'(ex_enable), 32'd1);
        tick();
        idle();
        check("mul_stall_cnt", 32'(stall_cnt), 32'(MUL_LAT - 1));
        check("mul_bpm8", 32'(bp_reg_mem), 32'd8);
        tick();

        // Flush at the second busy cycle kills the MUL.
        do_reset();
        drive(1, OP_MUL, 5'd8, 5'd1, 5'd2, 0);
        tick();
        drive(1, OP_ADD, 5'd4, 5'd8, 5'd2, 0);
        check("fl_bpm_a", 32'(bp_reg_mem), 32'd0);
        tick();
        drive(1, OP_ADD, 5'd4, 5'd8, 5'd2, 1);
        check("fl_nostall", 32'(stall_id), 32'd0);
        check("fl_noissue", 32'(ex_enable), 32'd0);
        check("fl_bpm_b", 32'(bp_reg_mem), 32'd0);
        tick();
        drive(1, OP_ADD, 5'd6, 5'd1, 5'd2, 0);
        check("fl_run", 32'(mul_busy), 32'd0);
        check("fl_issue", 32'(ex_enable), 32'd1);
        check("fl_bp_not8", 32'(bp_reg), 32'd0);
        check("fl_bpm_c", 32'(bp_reg_mem), 32'd0);
        tick();
        idle();
        check("fl_bp6", 32'(bp_reg), 32'd6);
        check("fl_bpm_d", 32'(bp_reg_mem), 32'd0);
        tick();

        // Randomized traffic; decode holds its instruction while stalled.
        do_reset();
        hold = 0;
        r_v = 0; r_op = 0; r_dst = 0; r_s1 = 0; r_s2 = 0;
        for (int c = 0; c < 600; c++) begin
            if (!hold) begin
                r_v = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 5))
                    0: r_op = OP_ADD;
                    1: r_op = OP_SUB;
                    2: r_op = OP_MUL;
                    3: r_op = OP_LDW;
                    4: r_op = OP_LDB;
                    default: r_op = 7'($urandom_range(0, 127));
                endcase
                r_dst = 5'($urandom_range(0, 7));
                r_s1  = 5'($urandom_range(0, 7));
                r_s2  = 5'($urandom_range(0, 7));
            end
            drive(r_v, r_op, r_dst, r_s1, r_s2, ($urandom_range(0, 15) == 0));
            hold = p_stall;
            tick();
        end

        // Asynchronous reset mid-MUL, checked before any clock edge.
        drive(1, OP_MUL, 5'd8, 5'd1, 5'd2, 0);
        while (!p_en) begin
            tick();
            drive(1, OP_MUL, 5'd8, 5'd1, 5'd2, 0);
        end
        tick();
        idle();
        check("pre_rst_busy", 32'(mul_busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ex_nop", 32'(ex_nop), 32'd1);
        check("arst_mul_busy", 32'(mul_busy), 32'd0);
        check("arst_bp_reg", 32'(bp_reg), 32'd0);
        check("arst_bp_reg_mem", 32'(bp_reg_mem), 32'd0);
        check("arst_stall_cnt", 32'(stall_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
